// File: rtl/fish_sprite_engine.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fish_sprite_engine
//
// Renders a 32x16 fish sprite over a scanned video raster. The fish swims
// horizontally at a fixed row. It pauses at each screen edge for a set number
// of frames, then turns around. The sprite image is fetched from an external
// ROM with one clock of read latency. Pixels equal to KEY_COLOR are treated
// as transparent.
//
// Ports
//   clk        in   1   pixel clock
//   reset_n    in   1   asynchronous active-low reset
//   video_on   in   1   raster is inside the visible area
//   x, y       in  10   current raster column / row
//   frame_tick in   1   one-cycle pulse per frame; the only time motion occurs
//   enable     in   1   motion enable (low on a frame_tick parks the fish)
//   speed      in   2   horizontal step per frame is speed+1 pixels
//   rom_row    out  4   sprite ROM row address (combinational)
//   rom_col    out  5   sprite ROM column address (combinational, mirrored
//                       when swimming left)
//   rom_color  in  12   sprite ROM data, valid one clk after the address
//   fish_x     out 10   sprite left column
//   fish_y     out 10   sprite top row (always Y_POS)
//   dir        out  1   0 = swimming right, 1 = swimming left
//   sprite_on  out  1   opaque sprite pixel, 2 clk after x/y
//   rgb_out    out 12   sprite pixel colour, 12'h000 when sprite_on is 0
// -----------------------------------------------------------------------------
module fish_sprite_engine #(
  parameter logic [9:0]  X_START     = 10'd100,
  parameter logic [9:0]  Y_POS       = 10'd240,
  parameter logic [9:0]  X_MAX       = 10'd639,
  parameter logic [3:0]  TURN_FRAMES = 4'd8,
  parameter logic [11:0] KEY_COLOR   = 12'h0F0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic [1:0]  speed,
  output logic [3:0]  rom_row,
  output logic [4:0]  rom_col,
  input  logic [11:0] rom_color,
  output logic [9:0]  fish_x,
  output logic [9:0]  fish_y,
  output logic        dir,
  output logic        sprite_on,
  output logic [11:0] rgb_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SWIM = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  turn_cnt;

  // Motion arithmetic, done 11 bits wide so edge tests never wrap.
  logic [10:0] step;
  logic [10:0] fx_wide;
  logic [10:0] fx_inc;
  logic [10:0] fx_dec;
  logic        at_right;
  logic        at_left;

  // Raster hit test and ROM addressing.
  logic [10:0] x_wide;
  logic [10:0] y_wide;
  logic [10:0] y_top;
  logic        hit_p0;
  logic [4:0]  dx_p0;
  logic        hit_p1;

  // Speed code 0..3 maps to a step of 1..4 pixels.
  function automatic logic [10:0] step_of(input logic [1:0] spd);
    return {9'd0, spd} + 11'd1;
  endfunction

  assign fish_y = Y_POS;

  always_comb begin
    step     = step_of(speed);
    fx_wide  = {1'b0, fish_x};
    fx_inc   = fx_wide + step;
    fx_dec   = fx_wide - step;
    // Right edge: the sprite's last column would pass X_MAX after the step.
    at_right = (fx_inc + 11'd32) > ({1'b0, X_MAX} + 11'd1);
    // Left edge: fish_x < step, seen as a borrow out of the subtraction.
    at_left  = fx_dec[10];
  end

  // ---------------------------------------------------------------------------
  // Stage 0: combinational hit test and ROM address from the live raster.
  // ---------------------------------------------------------------------------
  always_comb begin
    x_wide  = {1'b0, x};
    y_wide  = {1'b0, y};
    y_top   = {1'b0, Y_POS};
    hit_p0  = video_on &&
              (x_wide >= fx_wide) && (x_wide <= fx_wide + 11'd31) &&
              (y_wide >= y_top)   && (y_wide <= y_top + 11'd15);
    // Only the low bits matter: inside a hit the offsets are below 32 / 16.
    dx_p0   = x[4:0] - fish_x[4:0];
    rom_row = 4'd0;
    rom_col = 5'd0;
    if (hit_p0) begin
      rom_row = y[3:0] - Y_POS[3:0];
      rom_col = dir ? (5'd31 - dx_p0) : dx_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: hit delayed to line up with the ROM read data.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_p1 <= 1'b0;
    end else begin
      hit_p1 <= hit_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: transparency key and registered pixel output.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sprite_on <= 1'b0;
      rgb_out   <= 12'h000;
    end else begin
      sprite_on <= hit_p1 && (rom_color != KEY_COLOR);
      rgb_out   <= (hit_p1 && (rom_color != KEY_COLOR)) ? rom_color : 12'h000;
    end
  end

  // Motion FSM: everything here advances only on frame_tick. Dropping enable
  // parks the fish in IDLE with position, direction and counter kept; leaving
  // IDLE always resumes swimming, so any unfinished turn pause is abandoned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fish_x   <= X_START;
      dir      <= 1'b0;
      turn_cnt <= 4'd0;
    end else if (frame_tick) begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SWIM;
          end
        end
        SWIM: begin
          if (!enable) begin
            state <= IDLE;
          end else if (!dir) begin
            if (at_right) begin
              fish_x   <= X_MAX - 10'd31;
              turn_cnt <= TURN_FRAMES;
              state    <= TURN;
            end else begin
              fish_x <= fx_inc[9:0];
            end
          end else begin
            if (at_left) begin
              fish_x   <= 10'd0;
              turn_cnt <= TURN_FRAMES;
              state    <= TURN;
            end else begin
              fish_x <= fx_dec[9:0];
            end
          end
        end
        TURN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (turn_cnt <= 4'd1) begin
            // A count of 0 (TURN_FRAMES = 0) behaves like a one-frame pause.
            dir      <= ~dir;
            turn_cnt <= 4'd0;
            state    <= SWIM;
          end else begin
            turn_cnt <= turn_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fish_sprite_engine.sv
`timescale 1ns/1ps
// Directed bench for fish_sprite_engine with default parameters.
module tb_fish_sprite_engine;

  logic        clk;
  logic        reset_n;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        frame_tick;
  logic        enable;
  logic [1:0]  speed;
  logic [3:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] rom_color;
  logic [9:0]  fish_x;
  logic [9:0]  fish_y;
  logic        dir;
  logic        sprite_on;
  logic [11:0] rgb_out;

  int total;
  int bad;

  fish_sprite_engine dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .enable     (enable),
    .speed      (speed),
    .rom_row    (rom_row),
    .rom_col    (rom_col),
    .rom_color  (rom_color),
    .fish_x     (fish_x),
    .fish_y     (fish_y),
    .dir        (dir),
    .sprite_on  (sprite_on),
    .rgb_out    (rgb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_clk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; video_on = 1'b0; x = 10'd0; y = 10'd0;
    frame_tick = 1'b0; enable = 1'b0; speed = 2'd0; rom_color = 12'h000;
    #12;
    total++; if (fish_x !== 10'd100) begin bad++; $display("FAIL rst_fish_x got=%0d want=100", fish_x); end
    total++; if (fish_y !== 10'd240) begin bad++; $display("FAIL rst_fish_y got=%0d want=240", fish_y); end
    total++; if (dir !== 1'b0) begin bad++; $display("FAIL rst_dir got=%b want=0", dir); end
    total++; if (sprite_on !== 1'b0 || rgb_out !== 12'h000) begin bad++; $display("FAIL rst_pixel got=%b/%h want=0/000", sprite_on, rgb_out); end
    total++; if (rom_row !== 4'd0 || rom_col !== 5'd0) begin bad++; $display("FAIL rst_rom got=%0d/%0d want=0/0", rom_row, rom_col); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    step_clk(1);
  endtask

  task automatic test_pixel_hit();
    video_on = 1'b1; x = 10'd105; y = 10'd243; rom_color = 12'h88F;
    #1;
    total++; if (rom_col !== 5'd5 || rom_row !== 4'd3) begin bad++; $display("FAIL hit_addr got=col%0d row%0d want=col5 row3", rom_col, rom_row); end
    step_clk(1);
    total++; if (sprite_on !== 1'b0) begin bad++; $display("FAIL hit_lat1 got=%b want=0", sprite_on); end
    step_clk(1);
    total++; if (sprite_on !== 1'b1 || rgb_out !== 12'h88F) begin bad++; $display("FAIL hit_pixel got=%b/%h want=1/88f", sprite_on, rgb_out); end
    x = 10'd131; y = 10'd255; #1;
    total++; if (rom_col !== 5'd31 || rom_row !== 4'd15) begin bad++; $display("FAIL hit_corner got=col%0d row%0d want=col31 row15", rom_col, rom_row); end
    x = 10'd132; #1;
    total++; if (rom_col !== 5'd0 || rom_row !== 4'd0) begin bad++; $display("FAIL miss_x132 got=col%0d row%0d want=0/0", rom_col, rom_row); end
    x = 10'd105; y = 10'd256; #1;
    total++; if (rom_col !== 5'd0 || rom_row !== 4'd0) begin bad++; $display("FAIL miss_y256 got=col%0d row%0d want=0/0", rom_col, rom_row); end
    x = 10'd99; y = 10'd243; #1;
    total++; if (rom_col !== 5'd0 || rom_row !== 4'd0) begin bad++; $display("FAIL miss_x99 got=col%0d row%0d want=0/0", rom_col, rom_row); end
    x = 10'd105; video_on = 1'b0; #1;
    total++; if (rom_col !== 5'd0 || rom_row !== 4'd0) begin bad++; $display("FAIL miss_blank got=col%0d row%0d want=0/0", rom_col, rom_row); end
    step_clk(2);
    total++; if (sprite_on !== 1'b0 || rgb_out !== 12'h000) begin bad++; $display("FAIL miss_pixel got=%b/%h want=0/000", sprite_on, rgb_out); end
  endtask

  task automatic test_key_color();
    video_on = 1'b1; x = 10'd105; y = 10'd243; rom_color = 12'h0F0;
    step_clk(2);
    total++; if (sprite_on !== 1'b0 || rgb_out !== 12'h000) begin bad++; $display("FAIL key_pixel got=%b/%h want=0/000", sprite_on, rgb_out); end
    video_on = 1'b0; rom_color = 12'h000;
    step_clk(2);
  endtask

  task automatic test_swim_right();
    enable = 1'b0;
    frames(2);
    total++; if (fish_x !== 10'd100) begin bad++; $display("FAIL idle_hold got=%0d want=100", fish_x); end
    enable = 1'b1; speed = 2'd3;
    frames(20);
    total++; if (fish_x !== 10'd176 || dir !== 1'b0) begin bad++; $display("FAIL swim20 got=%0d dir%b want=176 dir0", fish_x, dir); end
    frames(107);
    speed = 2'd1;
    frames(1);
    total++; if (fish_x !== 10'd606) begin bad++; $display("FAIL reach606 got=%0d want=606", fish_x); end
  endtask

  task automatic test_right_edge();
    speed = 2'd3;
    frames(1);
    total++; if (fish_x !== 10'd608 || dir !== 1'b0) begin bad++; $display("FAIL right_clamp got=%0d dir%b want=608 dir0", fish_x, dir); end
    frames(7);
    total++; if (fish_x !== 10'd608 || dir !== 1'b0) begin bad++; $display("FAIL turn_wait got=%0d dir%b want=608 dir0", fish_x, dir); end
    frames(1);
    total++; if (dir !== 1'b1 || fish_x !== 10'd608) begin bad++; $display("FAIL turn_flip got=%0d dir%b want=608 dir1", fish_x, dir); end
    frames(1);
    total++; if (fish_x !== 10'd604) begin bad++; $display("FAIL swim_left got=%0d want=604", fish_x); end
  endtask

  task automatic test_left_edge();
    frames(150);
    speed = 2'd1;
    frames(1);
    total++; if (fish_x !== 10'd2) begin bad++; $display("FAIL reach2 got=%0d want=2", fish_x); end
    speed = 2'd3;
    frames(1);
    total++; if (fish_x !== 10'd0 || dir !== 1'b1) begin bad++; $display("FAIL left_clamp got=%0d dir%b want=0 dir1", fish_x, dir); end
    video_on = 1'b1; x = 10'd0; y = 10'd240; #1;
    total++; if (rom_col !== 5'd31 || rom_row !== 4'd0) begin bad++; $display("FAIL mirror0 got=col%0d row%0d want=col31 row0", rom_col, rom_row); end
    x = 10'd31; #1;
    total++; if (rom_col !== 5'd0) begin bad++; $display("FAIL mirror31 got=%0d want=0", rom_col); end
    video_on = 1'b0;
    step_clk(2);
  endtask

  task automatic test_enable_drop();
    frames(3);
    enable = 1'b0;
    frames(1);
    frames(3);
    total++; if (fish_x !== 10'd0 || dir !== 1'b1) begin bad++; $display("FAIL park got=%0d dir%b want=0 dir1", fish_x, dir); end
    enable = 1'b1;
    frames(1);
    total++; if (fish_x !== 10'd0 || dir !== 1'b1) begin bad++; $display("FAIL resume got=%0d dir%b want=0 dir1", fish_x, dir); end
    // Resumes in SWIM: one tick re-enters TURN with a fresh count of 8.
    frames(6);
    total++; if (dir !== 1'b1) begin bad++; $display("FAIL turn_discard got=dir%b want=dir1", dir); end
    frames(3);
    total++; if (dir !== 1'b0 || fish_x !== 10'd0) begin bad++; $display("FAIL turn_again got=%0d dir%b want=0 dir0", fish_x, dir); end
    frames(1);
    total++; if (fish_x !== 10'd4) begin bad++; $display("FAIL swim_out got=%0d want=4", fish_x); end
  endtask

  task automatic test_reset_mid_swim();
    video_on = 1'b1; x = 10'd10; y = 10'd245; rom_color = 12'h123;
    step_clk(2);
    total++; if (sprite_on !== 1'b1 || rgb_out !== 12'h123) begin bad++; $display("FAIL pre_rst_pixel got=%b/%h want=1/123", sprite_on, rgb_out); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (fish_x !== 10'd100 || dir !== 1'b0) begin bad++; $display("FAIL async_rst_pos got=%0d dir%b want=100 dir0", fish_x, dir); end
    total++; if (sprite_on !== 1'b0 || rgb_out !== 12'h000) begin bad++; $display("FAIL async_rst_pixel got=%b/%h want=0/000", sprite_on, rgb_out); end
    x = 10'd105; #1;
    total++; if (rom_col !== 5'd5 || rom_row !== 4'd5) begin bad++; $display("FAIL rst_rom_track got=col%0d row%0d want=col5 row5", rom_col, rom_row); end
    video_on = 1'b0;
    step_clk(1);
    reset_n = 1'b1;
    step_clk(1);
    frames(1);
    total++; if (fish_x !== 10'd100) begin bad++; $display("FAIL post_rst_idle got=%0d want=100", fish_x); end
    frames(1);
    total++; if (fish_x !== 10'd104) begin bad++; $display("FAIL post_rst_swim got=%0d want=104", fish_x); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_pixel_hit();
    test_key_color();
    test_swim_right();
    test_right_edge();
    test_left_edge();
    test_enable_drop();
    test_reset_mid_swim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fish_sprite_engine.md
FISH_SPRITE_ENGINE -- requirements
Module: fish_sprite_engine

Interface
REQ-001 SHALL have parameter X_START, default 10'd100, fish_x after reset.
REQ-002 SHALL have parameter Y_POS, default 10'd240, constant sprite top row (fish_y).
REQ-003 SHALL have parameter X_MAX, default 10'd639, rightmost visible column.
REQ-004 SHALL have parameter TURN_FRAMES, default 4'd8, frames paused at each edge before reversing.
REQ-005 SHALL have parameter KEY_COLOR, default 12'h0F0, transparent colour in sprite ROM data.
REQ-006 SHALL have one clock and asynchronous active-low reset: clk  in  1  pixel clock; reset_n  in  1  async active-low reset.
REQ-007 SHALL have ports: video_on  in  1  visible area; x  in  10  current pixel column; y  in  10  current pixel row.
REQ-008 SHALL have ports: frame_tick  in  1  one-cycle pulse per frame; enable  in  1  motion enable; speed  in  2  step select.
REQ-009 SHALL have ports: rom_row  out  4  sprite ROM row; rom_col  out  5  sprite ROM column; rom_color  in  12  ROM data, valid one clk after address.
REQ-010 SHALL have ports: fish_x  out  10; fish_y  out  10; dir  out  1 (0 = swimming right, 1 = left); sprite_on  out  1; rgb_out  out  12.

Function
REQ-011 Hit SHALL be video_on && fish_x <= x <= fish_x+31 && Y_POS <= y <= Y_POS+15, evaluated on unregistered inputs.
REQ-012 When hit: rom_row SHALL = y-Y_POS; rom_col SHALL = x-fish_x if dir=0, else 31-(x-fish_x) (horizontal mirror); when no hit both SHALL be 0.
REQ-013 hit SHALL be registered once (hit_d) to align with rom_color's one-clk latency.
REQ-014 sprite_on SHALL be registered as hit_d && (rom_color != KEY_COLOR); rgb_out SHALL be registered as rom_color when that term is 1, else 12'h000.
REQ-015 Total latency x/y -> sprite_on/rgb_out SHALL be exactly 2 clk; pipeline SHALL stall for no input.
REQ-016 FSM states SHALL be IDLE, SWIM, TURN; position and dir SHALL change only on cycles with frame_tick=1.
REQ-017 IDLE: SHALL go to SWIM on frame_tick && enable; position held.
REQ-018 SWIM: on frame_tick, step = speed+1 (1..4 px); dir=0 -> fish_x += step; dir=1 -> fish_x -= step.
REQ-019 Right edge: if dir=0 and fish_x+32+step > X_MAX+1, fish_x SHALL clamp to X_MAX-31 and FSM SHALL enter TURN with turn counter loaded to TURN_FRAMES.
REQ-020 Left edge: if dir=1 and fish_x < step, fish_x SHALL clamp to 0 and FSM SHALL enter TURN with counter loaded.
REQ-021 TURN: counter SHALL decrement on each frame_tick; on the frame_tick where it equals 1, dir SHALL toggle and FSM SHALL enter SWIM (TURN_FRAMES=0 treated as 1).
REQ-022 enable low on a frame_tick in SWIM or TURN SHALL force IDLE, keeping fish_x, dir, counter; re-enable SHALL resume SWIM in stored dir (remaining TURN frames discarded).
REQ-023 fish_x update SHALL use 11-bit intermediate arithmetic; fish_x SHALL never leave 0..X_MAX-31.
REQ-024 speed changes SHALL take effect on the next frame_tick; fish_y SHALL always equal Y_POS.

Reset
REQ-025 reset_n low SHALL asynchronously set: state IDLE, fish_x=X_START, dir=0, counter=0, hit_d=0, sprite_on=0, rgb_out=12'h000.
REQ-026 Reset mid-TURN or mid-SWIM SHALL discard state; first motion after release requires frame_tick && enable.
REQ-027 rom_row/rom_col SHALL remain combinational and reflect reset fish_x/dir immediately.

Verification
REQ-028 Reset, x=105,y=243,video_on=1, rom_color=12'h88F -> rom_col=5,rom_row=3; two clk later sprite_on=1, rgb_out=12'h88F.
REQ-029 Same pixel with rom_color=12'h0F0 -> sprite_on=0, rgb_out=0 after 2 clk; x=99 or video_on=0 -> no hit, rom_row/col=0.
REQ-030 enable=1, speed=3, 20 frame_ticks from reset -> fish_x=100+4*19=176 (first tick leaves IDLE), dir=0.
REQ-031 Force fish_x=606, dir=0, speed=3, frame_tick -> fish_x=608, TURN; 8 more frame_ticks -> dir=1, SWIM; next tick fish_x=604.
REQ-032 dir=1, fish_x=2, speed=3, frame_tick -> fish_x=0, TURN; x=fish_x -> rom_col=31 (mirror).
REQ-033 enable dropped on tick during TURN, counter=5 -> IDLE, fish_x held; re-enable -> SWIM, dir unchanged; reset_n pulse mid-SWIM -> fish_x=100, outputs 0 immediately.
